// File: rtl/mips_pkg.sv
// Purpose: shared types and MIPS32 encoding constants for the instruction encoder.
// Contents: mnemonic codes (mnem_t), opcode/funct values, encoder FSM states,
//           and small helpers that assemble R/I/J format words.
package mips_pkg;

  // Mnemonic codes as presented on the input stream; codes 23..31 are illegal.
  typedef enum logic [4:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR,
    M_LW, M_SW, M_BEQ, M_BNE, M_ADDI, M_ORI, M_ANDI, M_XORI,
    M_SLTI, M_SLTIU, M_LH, M_LB, M_LBU, M_LUI, M_BLEZ, M_J, M_JAL
  } mnem_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // R-type word; shamt is always zero for the supported set.
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Purpose: instruction input stream plus instruction-memory write bus of the encoder.
// Ports: in_valid/in_ready handshake with mnem/rs/rt/rd/imm/target fields;
//        imem_we/imem_addr/imem_wd write strobe, word address and data.
interface instr_encoder_if #(
  parameter int AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    mnem;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;

  // Producer of symbolic instructions / consumer of memory writes.
  modport master (
    output in_valid, mnem, rs, rt, rd, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wd
  );

  // The encoder itself.
  modport slave (
    input  in_valid, mnem, rs, rt, rd, imm, target,
    output in_ready, imem_we, imem_addr, imem_wd
  );
endinterface

// File: rtl/instr_pack.sv
// Purpose: combinational map from mnemonic + fields to a 32-bit MIPS32 word.
// Ports: mnem_i/rs_i/rt_i/rd_i/imm_i/target_i in; word_o encoded word,
//        legal_o low for unknown mnemonic codes (word_o is then zero).
module instr_pack
  import mips_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  // Fields a format does not use are simply never routed into the word.
  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (mnem_i)
      M_ADD:   word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
      M_SUB:   word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
      M_AND:   word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
      M_OR:    word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
      M_SLT:   word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
      M_JR:    word_o = r_word(rs_i, 5'd0, 5'd0, FN_JR);
      M_LW:    word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
      M_SW:    word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
      M_BEQ:   word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
      M_BNE:   word_o = i_word(OP_BNE, rs_i, rt_i, imm_i);
      M_ADDI:  word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
      M_ORI:   word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
      M_ANDI:  word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
      M_XORI:  word_o = i_word(OP_XORI, rs_i, rt_i, imm_i);
      M_SLTI:  word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
      M_SLTIU: word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
      M_LH:    word_o = i_word(OP_LH, rs_i, rt_i, imm_i);
      M_LB:    word_o = i_word(OP_LB, rs_i, rt_i, imm_i);
      M_LBU:   word_o = i_word(OP_LBU, rs_i, rt_i, imm_i);
      M_LUI:   word_o = i_word(OP_LUI, 5'd0, rt_i, imm_i);   // rs forced to 0
      M_BLEZ:  word_o = i_word(OP_BLEZ, rs_i, 5'd0, imm_i);  // rt forced to 0
      M_J:     word_o = j_word(OP_J, target_i);
      M_JAL:   word_o = j_word(OP_JAL, target_i);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Purpose: encode a stream of symbolic MIPS32 instructions into consecutive imem words.
// Latency: one cycle from accepted transfer to imem_we pulse (registered word/address).
// Backpressure: in_ready only in LOAD, below DEPTH words, and while finish is low.
// Ports: clk/reset (sync, active-high); start/finish session control; bus = input
//        stream + imem write port; count words written; busy/done state; err sticky.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           finish,
  instr_encoder_if.slave bus,
  output logic [AW:0]    count,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  logic [31:0]   pack_word;
  logic          pack_legal;
  logic          rdy;
  logic          xfer;
  logic          full;

  instr_pack u_pack (
    .mnem_i   (bus.mnem),
    .rs_i     (bus.rs),
    .rt_i     (bus.rt),
    .rd_i     (bus.rd),
    .imm_i    (bus.imm),
    .target_i (bus.target),
    .word_o   (pack_word),
    .legal_o  (pack_legal)
  );

  // count_q already includes a write that is still pending on the output
  // register, because it advances at the accepting edge; comparing it alone
  // against DEPTH is therefore the same as count + pending.
  assign full = (count_q >= DEPTH_C);
  assign rdy  = (state_q == S_LOAD) && !full && !finish;
  assign xfer = bus.in_valid && rdy;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (pack_legal) begin
            we_d    = 1'b1;
            addr_d  = count_q[AW-1:0];
            wd_d    = pack_word;
            count_d = count_q + ONE_C;
          end else begin
            // Illegal code is consumed but leaves no trace in memory.
            err_d = 1'b1;
          end
        end
        // A write already registered still pulses this cycle, so leaving LOAD
        // here never drops it; finish also holds in_ready low.
        if (finish || full) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.imem_we   = we_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_wd   = wd_q;
  assign count         = count_q;
  assign busy          = (state_q == S_LOAD);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset, start, finish;
  logic [AW:0] count, count4;
  logic busy, done, err, busy4, done4, err4;

  instr_encoder_if #(.AW(AW)) b64 ();
  instr_encoder_if #(.AW(AW)) b4 ();

  instr_encoder #(.AW(AW), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .bus(b64.slave),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  instr_encoder #(.AW(AW), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .bus(b4.slave),
    .count(count4), .busy(busy4), .done(done4), .err(err4)
  );

  // The small-depth instance sees exactly the same stream.
  assign b4.in_valid = b64.in_valid;
  assign b4.mnem     = b64.mnem;
  assign b4.rs       = b64.rs;
  assign b4.rt       = b64.rt;
  assign b4.rd       = b64.rd;
  assign b4.imm      = b64.imm;
  assign b4.target   = b64.target;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference encoding tables indexed by mnemonic code:
  // kind 0=R, 1=JR, 2=I, 3=LUI, 4=BLEZ, 5=J/JAL; code is funct for R/JR, opcode otherwise.
  int         kind_tab [23];
  logic [5:0] code_tab [23];

  function automatic logic [32:0] ref_enc(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm,
                                          input logic [25:0] tg);
    if (m > 22) return 33'd0;
    case (kind_tab[m])
      0:       return {1'b1, 6'd0, rs, rt, rd, 5'd0, code_tab[m]};
      1:       return {1'b1, 6'd0, rs, 15'd0, code_tab[m]};
      2:       return {1'b1, code_tab[m], rs, rt, imm};
      3:       return {1'b1, code_tab[m], 5'd0, rt, imm};
      4:       return {1'b1, code_tab[m], rs, 5'd0, imm};
      default: return {1'b1, code_tab[m], tg};
    endcase
  endfunction

  typedef struct {
    logic [4:0]  m;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tg;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t tab [16];

  task automatic drive(input logic v, input logic [4:0] m, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tg);
    b64.in_valid = v;
    b64.mnem     = m;
    b64.rs       = rs;
    b64.rt       = rt;
    b64.rd       = rd;
    b64.imm      = imm;
    b64.target   = tg;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
  endtask

  // Session control tasks are entered and left just after a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  int          ea;
  int          m_st, m_cnt;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wd;
  logic        m_we, m_err;

  initial begin
    kind_tab = '{0,0,0,0,0,1,2,2,2,2,2,2,2,2,2,2,2,2,2,3,4,5,5};
    code_tab = '{6'h20,6'h22,6'h24,6'h25,6'h2A,6'h08,6'h23,6'h2B,6'h04,6'h05,6'h08,6'h0D,
                 6'h0C,6'h0E,6'h0A,6'h0B,6'h21,6'h20,6'h24,6'h0F,6'h06,6'h02,6'h03};

    //          m      rs     rt     rd     imm        target         legal word
    tab[0]  = '{5'd10, 5'd0,  5'd8,  5'd31, 16'h0005, 26'h3FFFFFF, 1'b1, 32'h20080005}; // ADDI
    tab[1]  = '{5'd0,  5'd8,  5'd9,  5'd10, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h01095020}; // ADD
    tab[2]  = '{5'd6,  5'd8,  5'd9,  5'd7,  16'h0004, 26'h0000001, 1'b1, 32'h8D090004}; // LW
    tab[3]  = '{5'd8,  5'd8,  5'd9,  5'd0,  16'hFFFF, 26'h0000000, 1'b1, 32'h1109FFFF}; // BEQ
    tab[4]  = '{5'd21, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000011, 1'b1, 32'h08000011}; // J
    tab[5]  = '{5'd22, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000011, 1'b1, 32'h0C000011}; // JAL
    tab[6]  = '{5'd25, 5'd1,  5'd2,  5'd3,  16'h1111, 26'h0000000, 1'b0, 32'h00000000}; // illegal
    tab[7]  = '{5'd1,  5'd2,  5'd3,  5'd1,  16'hABCD, 26'h2AAAAAA, 1'b1, 32'h00430822}; // SUB
    tab[8]  = '{5'd23, 5'd4,  5'd5,  5'd6,  16'h2222, 26'h0000000, 1'b0, 32'h00000000}; // first illegal code
    tab[9]  = '{5'd4,  5'd5,  5'd6,  5'd4,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00A6202A}; // SLT
    tab[10] = '{5'd5,  5'd31, 5'd5,  5'd6,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h03E00008}; // JR
    tab[11] = '{5'd19, 5'd7,  5'd4,  5'd9,  16'h1234, 26'h3FFFFFF, 1'b1, 32'h3C041234}; // LUI
    tab[12] = '{5'd20, 5'd3,  5'd9,  5'd9,  16'h0010, 26'h3FFFFFF, 1'b1, 32'h18600010}; // BLEZ
    tab[13] = '{5'd7,  5'd29, 5'd31, 5'd2,  16'h0008, 26'h1555555, 1'b1, 32'hAFBF0008}; // SW
    tab[14] = '{5'd11, 5'd1,  5'd2,  5'd30, 16'h00FF, 26'h0000000, 1'b1, 32'h342200FF}; // ORI
    tab[15] = '{5'd18, 5'd4,  5'd5,  5'd31, 16'h0010, 26'h3FFFFFF, 1'b1, 32'h90850010}; // LBU

    reset = 1'b1; start = 1'b0; finish = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_we",    b64.imem_we, 0);
    chk("rst_addr",  b64.imem_addr, 0);
    chk("rst_wd",    b64.imem_wd, 0);
    chk("rst_count", count, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_rdy",   b64.in_ready, 0);
    reset = 1'b0;

    // Table of single instructions streamed back to back in one session.
    do_start();
    chk("start_busy", busy, 1);
    chk("start_count", count, 0);
    ea = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, tab[i].m, tab[i].rs, tab[i].rt, tab[i].rd, tab[i].imm, tab[i].tg);
      #1 chk($sformatf("tab%0d_rdy", i), b64.in_ready, 1);
      @(negedge clk);
      chk($sformatf("tab%0d_we", i), b64.imem_we, tab[i].legal);
      if (tab[i].legal) begin
        chk($sformatf("tab%0d_wd", i), b64.imem_wd, tab[i].word);
        chk($sformatf("tab%0d_addr", i), b64.imem_addr, ea);
        ea++;
      end else begin
        chk($sformatf("tab%0d_err", i), err, 1);
      end
      chk($sformatf("tab%0d_count", i), count, ea);
    end
    idle();
    @(negedge clk);
    chk("tab_err_sticky", err, 1);
    chk("tab_no_extra_we", b64.imem_we, 0);
    do_finish();
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    do_start();
    chk("restart_err", err, 0);
    chk("restart_count", count, 0);
    chk("restart_addr", b64.imem_addr, 0);

    // DEPTH=4 instance: six back-to-back instructions, only four fit.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd10, 5'd0, 5'd8, 5'd0, 16'(i), 26'd0);
      #1 chk($sformatf("d4_rdy%0d", i), b4.in_ready, (i < 4));
      @(negedge clk);
      chk($sformatf("d4_we%0d", i), b4.imem_we, (i < 4));
      if (i < 4) begin
        chk($sformatf("d4_addr%0d", i), b4.imem_addr, i);
        chk($sformatf("d4_wd%0d", i), b4.imem_wd, 32'h20080000 + i);
      end
    end
    chk("d4_count", count4, 4);
    chk("d4_done", done4, 1);
    chk("d4_busy", busy4, 0);
    chk("d4_err", err4, 0);
    chk("d4_rdy_after", b4.in_ready, 0);
    chk("d64_count6", count, 6);
    // finish with in_valid: no accept on either instance.
    finish = 1'b1;
    #1 chk("fin_valid_rdy4", b4.in_ready, 0);
    chk("fin_valid_rdy64", b64.in_ready, 0);
    @(negedge clk);
    finish = 1'b0;
    idle();
    chk("fin_valid_done4", done4, 1);
    chk("fin_valid_done64", done, 1);
    chk("fin_valid_we", b64.imem_we, 0);
    chk("fin_valid_count", count, 6);

    // finish right after a transfer: the pending write still lands.
    do_start();
    drive(1'b1, 5'd10, 5'd0, 5'd8, 5'd0, 16'h0007, 26'd0);
    @(negedge clk);
    finish = 1'b1;
    #1 chk("pend_rdy", b64.in_ready, 0);
    chk("pend_we", b64.imem_we, 1);
    chk("pend_wd", b64.imem_wd, 32'h20080007);
    @(negedge clk);
    finish = 1'b0;
    idle();
    chk("pend_done", done, 1);
    chk("pend_we_off", b64.imem_we, 0);
    chk("pend_count", count, 1);

    // reset on the transfer edge discards the write.
    do_start();
    drive(1'b1, 5'd10, 5'd0, 5'd8, 5'd0, 16'h0009, 26'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_we", b64.imem_we, 0);
    chk("rx_addr", b64.imem_addr, 0);
    chk("rx_wd", b64.imem_wd, 0);
    chk("rx_count", count, 0);
    chk("rx_busy", busy, 0);
    chk("rx_done", done, 0);
    chk("rx_err", err, 0);
    chk("rx_rdy", b64.in_ready, 0);
    reset = 1'b0;
    idle();

    // Randomized stream against a transaction-level model of the DEPTH=64 unit.
    m_st = 0; m_cnt = 0; m_addr = '0; m_wd = '0; m_we = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic v, st, fin, exp_rdy, was_full;
      int mn;
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tg;
      logic [32:0] e;
      @(negedge clk);
      chk("r_we", b64.imem_we, m_we);
      if (m_we) chk("r_wd", b64.imem_wd, m_wd);
      chk("r_addr", b64.imem_addr, m_addr);
      chk("r_count", count, m_cnt);
      chk("r_busy", busy, (m_st == 1));
      chk("r_done", done, (m_st == 2));
      chk("r_err", err, m_err);
      v   = ($urandom_range(0, 3) != 0);
      mn  = $urandom_range(0, 25);
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      tg  = 26'($urandom);
      st  = ($urandom_range(0, 15) == 0);
      fin = ($urandom_range(0, 199) == 0);
      start  = st;
      finish = fin;
      drive(v, 5'(mn), rs, rt, rd, imm, tg);
      exp_rdy = (m_st == 1) && (m_cnt < 64) && !fin;
      #1 chk("r_rdy", b64.in_ready, exp_rdy);
      m_we = 1'b0;
      if (m_st != 1) begin
        if (st) begin
          m_st = 1; m_cnt = 0; m_addr = '0; m_err = 1'b0;
        end
      end else begin
        was_full = (m_cnt == 64);
        if (v && exp_rdy) begin
          e = ref_enc(mn, rs, rt, rd, imm, tg);
          if (e[32]) begin
            m_we = 1'b1; m_addr = AW'(m_cnt); m_wd = e[31:0]; m_cnt++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (fin || was_full) m_st = 2;
      end
    end
    start = 1'b0;
    finish = 1'b0;
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential MIPS32 instruction encoder and loader. It is the producer-side counterpart of the main decoder.
- Accepts symbolic instructions (mnemonic plus register, immediate and target fields) over a valid/ready stream.
- Assembles each one into a 32-bit machine word and writes it to consecutive instruction-memory words.
- Used by the testbench and boot path to build programs whose opcode/funct encodings match exactly what the decoder expects.

Parameters:
- AW, 6, instruction-memory word-address width.
- DEPTH, 64, number of words that can be loaded (≤ 2**AW).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load session at address 0.
- finish  in  1  end the session; takes effect after any pending write.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept this cycle.
- mnem  in  5  mnemonic code (mnem_t).
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate or branch offset.
- target  in  26  jump word target.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  AW  write word address.
- imem_wd  out  32  encoded instruction word.
- count  out  AW+1  words written in the current session.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- err  out  1  sticky: an illegal mnemonic was seen.

Behaviour:
- Reset values: state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wd=0, count=0, err=0. A write pending at reset is discarded.
- States:
  - IDLE --start--> LOAD: address and count cleared, err cleared.
  - LOAD --finish, or count reaches DEPTH--> DONE.
  - DONE --start--> LOAD: same clearing as from IDLE.
  - start is ignored while in LOAD.
- in_ready = (state==LOAD) && (count + pending < DEPTH) && !finish.
- Transfer occurs when in_valid && in_ready.
- Latency:
  - Word is registered; imem_we is high exactly 1 cycle after the transfer, for exactly 1 cycle.
  - imem_addr = count at transfer time; count increments in the same cycle as imem_we.
  - Back-to-back transfers produce one write per cycle.
- Encoding, with fields placed as {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}:
  - R-type (op 000000, shamt 0): ADD funct 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - JR: {000000, rs, 0, 0, 0, 001000}.
  - I-type {op, rs, rt, imm}: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ORI 001101, ANDI 001100, XORI 001110, SLTI 001010, SLTIU 001011, LH 100001, LB 100000, LBU 100100.
  - LUI 001111: rs forced to 0.
  - BLEZ 000110: rt forced to 0.
  - J 000010 and JAL 000011: {op, target}.
  - Fields unused by a format are ignored, whatever their input value.
- Illegal mnemonic (code ≥ 23):
  - Transfer still completes (ready honoured).
  - No write; count and address unchanged.
  - err set and held until the next start or reset.
- finish together with a transfer in the same cycle: the transfer is not accepted (in_ready low). Enter DONE after any pending write completes.
- Full: once count == DEPTH, go to DONE automatically; in_ready stays low.
- done and busy are decoded from the state register, with no extra latency.

Decomposition:
- Package mips_pkg:
  - mnem_t enum (ADD=0 … JAL=22).
  - localparams for every opcode and funct value.
  - state_t {IDLE, LOAD, DONE}.
- One combinational sub-module, instr_pack: maps mnem + fields to {word, legal}. The top level holds the FSM, counters and output register.

Test Plan:
- start, then ADDI rs=0 rt=8 imm=5 → one cycle later imem_we=1, imem_addr=0, imem_wd=0x20080005, count=1.
- Back-to-back: ADD rd=10 rs=8 rt=9, LW rt=9 rs=8 imm=4, BEQ rs=8 rt=9 imm=0xFFFF → consecutive writes 0x01095020, 0x8D090004, 0x1109FFFF at addresses 0, 1, 2.
- J target=0x11, then JAL target=0x11 with rs/rt/rd = 31 → 0x08000011, then 0x0C000011 (register fields ignored).
- mnem=25 between two valid instructions → no write for it, err=1, following instruction written at the next address; a new start clears err.
- DEPTH=4: stream 6 instructions → 4 writes, done=1, in_ready=0 afterwards; assert finish with in_valid → no accept, DONE.
- reset asserted the cycle after a transfer → imem_we stays 0, all outputs return to their reset values, state IDLE.
